dadda_mac_acc: RTL and testbench

- Downstream consumer of the 8x8 Dadda multiplier's 16-bit product `op`; turns the combinational multiplier into a multiply-accumulate datapath.
- Sums a vector of products, delimited by `in_last`, into a wide accumulator.
- Presents the dot-product result with valid/ready handshake, overflow and truncation flags.
- Sits between the multiplier output and the result-capture/display logic.

---
 rtl/dadda_mac_acc.sv | 137 +++++++++++++
 tb/tb_dadda_mac_acc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mac_acc.sv
// dadda_mac_acc: multiply-accumulate back end for the 8x8 Dadda multiplier.
// Sums the vector of unsigned products arriving on `op` (closed by `in_last`,
// or cut short after MAX_TERMS products) into an ACC_W-bit accumulator. The
// result is then held for a valid/ready handshake.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset, highest priority
//   clr        synchronous abort: drops partial sum or pending result
//   in_valid   op/in_last valid this cycle
//   in_ready   block accepts a beat this cycle (combinational)
//   op         OP_W-bit unsigned product
//   in_last    marks the final product of a vector
//   out_valid  result available
//   out_ready  downstream takes the result
//   acc        accumulated sum of the vector (modulo 2^ACC_W)
//   out_cnt    number of products in the vector
//   ovf        sticky carry out of bit ACC_W-1 during the vector
//   trunc      vector ended by MAX_TERMS rather than in_last
//
// Handshake: a beat transfers on any cycle where in_valid && in_ready. A
// result transfers on any cycle where out_valid && out_ready. While out_valid
// is high and out_ready is low, acc/out_cnt/ovf/trunc hold steady. in_ready is
// low in HOLD, so no beat is accepted until the cycle after the result leaves.
module dadda_mac_acc #(
    parameter int OP_W      = 16,
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             ovf,
    output logic             trunc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_TERMS);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t             state;
    logic [ACC_W-1:0]   sum;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_r;
    logic               trunc_r;
    logic               valid_r;

    logic               beat;
    logic [ACC_W-1:0]   op_ext;
    logic [ACC_W:0]     sum_next;   // extra MSB captures the carry out
    logic [CNT_W-1:0]   cnt_inc;

    // in_ready is forced low while rst is high.
    assign in_ready = !rst && (state != HOLD);
    assign beat     = in_valid && in_ready;
    assign op_ext   = ACC_W'(op);
    assign sum_next = {1'b0, sum} + {1'b0, op_ext};
    assign cnt_inc  = cnt + ONE_C;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state   <= IDLE;
            sum     <= '0;
            cnt     <= '0;
            ovf_r   <= 1'b0;
            trunc_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        sum     <= op_ext;
                        cnt     <= ONE_C;
                        ovf_r   <= 1'b0;
                        trunc_r <= 1'b0;
                        if (in_last || (MAX_TERMS == 1)) begin
                            state   <= HOLD;
                            valid_r <= 1'b1;
                            trunc_r <= !in_last;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        sum <= sum_next[ACC_W-1:0];
                        cnt <= cnt_inc;
                        if (sum_next[ACC_W]) begin
                            ovf_r <= 1'b1;
                        end
                        if (in_last || (cnt_inc == MAX_C)) begin
                            state   <= HOLD;
                            valid_r <= 1'b1;
                            trunc_r <= !in_last;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state   <= IDLE;
                        valid_r <= 1'b0;
                        sum     <= '0;
                        cnt     <= '0;
                        ovf_r   <= 1'b0;
                        trunc_r <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = valid_r;
    assign acc       = sum;
    assign out_cnt   = cnt;
    assign ovf       = ovf_r;
    assign trunc     = trunc_r;

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Directed testbench for dadda_mac_acc. It drives two instances from the same
// inputs: the default ACC_W=24 instance and a narrow ACC_W=17 instance, which
// is used to force accumulator wrap.
module tb_dadda_mac_acc;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [15:0] op;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [23:0] acc;
    logic [8:0]  out_cnt;
    logic        ovf;
    logic        trunc;

    logic        in_ready_n;
    logic        out_valid_n;
    logic [16:0] acc_n;
    logic [8:0]  out_cnt_n;
    logic        ovf_n;
    logic        trunc_n;

    int n_vec;
    int n_err;

    dadda_mac_acc dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .out_cnt   (out_cnt),
        .ovf       (ovf),
        .trunc     (trunc)
    );

    dadda_mac_acc #(.ACC_W(17)) dut_n (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready_n),
        .op        (op),
        .in_last   (in_last),
        .out_valid (out_valid_n),
        .out_ready (out_ready),
        .acc       (acc_n),
        .out_cnt   (out_cnt_n),
        .ovf       (ovf_n),
        .trunc     (trunc_n)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat. On return it is 1 time unit after the capturing edge.
    task automatic send(input logic [15:0] v, input logic last);
        in_valid = 1'b1;
        op       = v;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // reset
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_acc", 32'(acc), 0);
        chk("rst_cnt", 32'(out_cnt), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_trunc", 32'(trunc), 0);
        chk("rel_in_ready", 32'(in_ready), 1);

        // basic: 300 + 65025 + 1
        send(16'd300, 1'b0);
        send(16'd65025, 1'b0);
        chk("basic_not_yet", 32'(out_valid), 0);
        send(16'd1, 1'b1);
        chk("basic_valid", 32'(out_valid), 1);
        chk("basic_acc", 32'(acc), 65326);
        chk("basic_cnt", 32'(out_cnt), 3);
        chk("basic_ovf", 32'(ovf), 0);
        chk("basic_trunc", 32'(trunc), 0);
        chk("basic_hold_ready", 32'(in_ready), 0);
        take();
        chk("basic_drop", 32'(out_valid), 0);
        chk("basic_ready_back", 32'(in_ready), 1);

        // backpressure with a waiting beat of 111
        send(16'd65025, 1'b1);
        in_valid = 1'b1;
        op       = 16'd111;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_acc", 32'(acc), 65025);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_drop", 32'(out_valid), 0);
        chk("bp_ready_back", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 1);
        chk("bp_next_acc", 32'(acc), 111);
        chk("bp_next_cnt", 32'(out_cnt), 1);
        take();

        // overflow on the 17-bit instance
        send(16'd65025, 1'b0);
        send(16'd65025, 1'b0);
        send(16'd65025, 1'b1);
        chk("ovf_valid", 32'(out_valid_n), 1);
        chk("ovf_acc17", 32'(acc_n), 64003);
        chk("ovf_flag17", 32'(ovf_n), 1);
        chk("ovf_cnt17", 32'(out_cnt_n), 3);
        chk("ovf_acc24", 32'(acc), 195075);
        chk("ovf_flag24", 32'(ovf), 0);
        take();
        send(16'd5, 1'b1);
        chk("ovf_next_acc17", 32'(acc_n), 5);
        chk("ovf_next_flag17", 32'(ovf_n), 0);
        take();

        // truncation at 256 terms
        for (int i = 0; i < 255; i++) begin
            send(16'd1, 1'b0);
        end
        chk("tr_not_yet", 32'(out_valid), 0);
        send(16'd1, 1'b0);
        chk("tr_valid", 32'(out_valid), 1);
        chk("tr_acc", 32'(acc), 256);
        chk("tr_cnt", 32'(out_cnt), 256);
        chk("tr_flag", 32'(trunc), 1);
        in_valid = 1'b1;
        op       = 16'd9;
        in_last  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("tr_stall_ready", 32'(in_ready), 0);
            chk("tr_stall_acc", 32'(acc), 256);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("tr_next_acc", 32'(acc), 9);
        chk("tr_next_cnt", 32'(out_cnt), 1);
        chk("tr_next_flag", 32'(trunc), 0);
        take();

        // abort with clr while a beat is presented
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        clr = 1'b1;
        send(16'd30, 1'b1);
        clr = 1'b0;
        chk("clr_no_result", 32'(out_valid), 0);
        tick();
        chk("clr_still_none", 32'(out_valid), 0);
        chk("clr_ready", 32'(in_ready), 1);
        send(16'd7, 1'b1);
        chk("clr_acc", 32'(acc), 7);
        chk("clr_cnt", 32'(out_cnt), 1);
        take();

        // reset while a result is pending
        send(16'd300, 1'b0);
        send(16'd65025, 1'b0);
        send(16'd1, 1'b1);
        chk("rh_pending", 32'(acc), 65326);
        rst = 1'b1;
        tick();
        chk("rh_in_ready", 32'(in_ready), 0);
        chk("rh_valid", 32'(out_valid), 0);
        chk("rh_acc", 32'(acc), 0);
        chk("rh_cnt", 32'(out_cnt), 0);
        chk("rh_ovf", 32'(ovf), 0);
        chk("rh_trunc", 32'(trunc), 0);
        rst = 1'b0;
        #1;
        chk("rh_ready_back", 32'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
